// File: rtl/bus_fabric.sv
// bus_fabric: decoded CPU-to-slave bus with one-hot select, wait states, ready handshake and timeout.
// Define BUS_FABRIC_ERRLOG_EN to build the err_addr/err_count error log.
module bus_fabric #(
    parameter int                    NSLAVES  = 10,
    parameter int                    AW       = 32,
    parameter int                    DW       = 16,
    parameter logic [NSLAVES*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLAVES*AW-1:0] SLV_MASK = '0,
    parameter logic [NSLAVES*4-1:0]  SLV_WAIT = '0,
    parameter int                    TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_write,
    input  logic [AW-1:0]         cpu_addr,
    input  logic [DW-1:0]         cpu_wdata,
    output logic [DW-1:0]         cpu_rdata,
    output logic                  cpu_ack,
    output logic                  bus_error,
    output logic [NSLAVES-1:0]    slv_sel,
    output logic                  slv_write,
    output logic [AW-1:0]         slv_addr,
    output logic [DW-1:0]         slv_wdata,
    input  logic [NSLAVES*DW-1:0] slv_rdata,
    input  logic [NSLAVES-1:0]    slv_ready,
    output logic [AW-1:0]         err_addr,
    output logic [7:0]            err_count
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

    state_t               state_q, state_d;
    logic [NSLAVES-1:0]   sel_q, sel_d, dec_sel;
    logic                 wr_q, wr_d, ack_q, ack_d, err_q, err_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d, rdata_q, rdata_d, rd_mux;
    logic [3:0]           wait_q, wait_d, dec_wait;
    logic [15:0]          to_q, to_d;
    logic                 done, expire;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        dec_sel  = '0;
        dec_wait = '0;
        rd_mux   = '0;
        for (int i = NSLAVES - 1; i >= 0; i--) begin
            if ((cpu_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                dec_sel    = '0;
                dec_sel[i] = 1'b1;
                dec_wait   = SLV_WAIT[i*4 +: 4];
            end
        end
        for (int i = 0; i < NSLAVES; i++)
            rd_mux = rd_mux | ({DW{sel_q[i]}} & slv_rdata[i*DW +: DW]);
    end

    assign done   = (wait_q == 4'd0) && |(slv_ready & sel_q);
    assign expire = (TO_LIM != 16'd0) && (to_q == TO_LIM - 16'd1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wait_d  = wait_q;
        to_d    = to_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    to_d    = '0;
                    if (|dec_sel) begin
                        sel_d   = dec_sel;
                        wr_d    = cpu_write;
                        wait_d  = dec_wait;
                        state_d = ACCESS;
                    end else begin
                        wr_d    = 1'b0;
                        rdata_d = '0;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            ACCESS: begin
                wait_d = (wait_q != 4'd0) ? wait_q - 4'd1 : wait_q;
                to_d   = to_q + 16'd1;
                if (done || expire) begin
                    rdata_d = (done && !wr_q) ? rd_mux : '0;
                    sel_d   = '0;
                    wr_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = !done;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            to_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            to_q    <= to_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ack   = ack_q;
    assign bus_error = err_q;
    assign slv_sel   = sel_q;
    assign slv_write = wr_q;
    assign slv_addr  = addr_q;
    assign slv_wdata = wdata_q;

`ifdef BUS_FABRIC_ERRLOG_EN
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [7:0]    err_count_q, err_count_d;

    always_comb begin
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (ack_d && err_d) begin
            err_addr_d  = addr_d;
            err_count_d = (err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
`else
    assign err_addr  = '0;
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: randomized scoreboard bench for bus_fabric with a 4-slave map and TIMEOUT=8.
// Expected acks come from decode rules and latency arithmetic; a negedge monitor checks them.
module tb_bus_fabric;
    localparam int TO = 8;
    localparam logic [31:0] BASES [4] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000};
    localparam logic [31:0] MASKS [4] = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFE_0000};
    localparam int          WAITS [4] = '{0, 1, 2, 3};
    localparam logic [127:0] BASE_F = {BASES[3], BASES[2], BASES[1], BASES[0]};
    localparam logic [127:0] MASK_F = {MASKS[3], MASKS[2], MASKS[1], MASKS[0]};
    localparam logic [15:0]  WAIT_F = {4'd3, 4'd2, 4'd1, 4'd0};

    typedef struct {
        int          acc;
        int          ack;
        int          sel_end;
        logic [3:0]  sel;
        logic        wr;
        logic [31:0] addr;
        logic [15:0] wdata;
        logic        err;
        logic [15:0] rdata;
        logic [31:0] eaddr;
        logic [7:0]  ecnt;
    } exp_t;

    logic        clk, rst_n, cpu_req, cpu_write, cpu_ack, bus_error, slv_write;
    logic [31:0] cpu_addr, slv_addr, err_addr;
    logic [15:0] cpu_wdata, cpu_rdata, slv_wdata;
    logic [3:0]  slv_sel, slv_ready;
    logic [63:0] slv_rdata;
    logic [7:0]  err_count;

    int   cyc = 0, rdy2_from = 0, vectors = 0, miscompares = 0;
    bit   mon_en = 0;
    exp_t exp_q[$];
    exp_t m_e;
    logic [3:0]  m_sel;
    logic [31:0] log_addr = '0;
    logic [7:0]  log_cnt = '0;

    bus_fabric #(
        .NSLAVES(4), .AW(32), .DW(16),
        .SLV_BASE(BASE_F), .SLV_MASK(MASK_F), .SLV_WAIT(WAIT_F), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_write(cpu_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_ack(cpu_ack), .bus_error(bus_error), .slv_sel(slv_sel),
        .slv_write(slv_write), .slv_addr(slv_addr), .slv_wdata(slv_wdata),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready),
        .err_addr(err_addr), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave 2 is the only stalling slave; it raises ready from cycle rdy2_from onward.
    assign slv_ready = {1'b1, cyc >= rdy2_from, 2'b11};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++)
            if ((a & MASKS[i]) == BASES[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] rand_addr();
        int r = int'($urandom_range(0, 4));
        return (r == 4) ? {16'($urandom_range(4, 65535)), 16'($urandom)} : {16'(r), 16'($urandom)};
    endfunction

    task automatic rnd_rdata();
        for (int i = 0; i < 4; i++) slv_rdata[i*16 +: 16] = 16'($urandom);
    endtask

    task automatic idle(input int n);
        cpu_req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Issue one request from a negedge; chain means the fabric is in its ack cycle right now.
    task automatic txn(input logic [31:0] a, input logic w, input logic [15:0] d, input int hold, input bit chain);
        exp_t e;
        int   idx, k, h;
        bit   got;
        idx       = decode(a);
        e.acc     = cyc + (chain ? 2 : 1);
        rdy2_from = e.acc + hold;
        e.addr    = a;
        e.wdata   = d;
        e.wr      = (idx >= 0) && w;
        e.sel     = '0;
        e.err     = 1'b1;
        e.rdata   = '0;
        e.ack     = e.acc;
        e.sel_end = e.acc - 1;
        if (idx >= 0) begin
            h     = (idx == 2) ? hold : 0;
            k     = 1 + ((WAITS[idx] > h) ? WAITS[idx] : h);
            e.sel = 4'(1 << idx);
            e.ack = e.acc + ((k > TO) ? TO : k);
            e.sel_end = e.ack - 1;
            if (k <= TO) begin
                e.err   = 1'b0;
                e.rdata = w ? 16'h0 : slv_rdata[idx*16 +: 16];
            end
        end
`ifdef BUS_FABRIC_ERRLOG_EN
        if (e.err) begin
            log_cnt  = (log_cnt == 8'hFF) ? log_cnt : log_cnt + 8'd1;
            log_addr = a;
        end
`endif
        e.eaddr   = log_addr;
        e.ecnt    = log_cnt;
        cpu_req   = 1'b1;
        cpu_addr  = a;
        cpu_write = w;
        cpu_wdata = d;
        exp_q.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = cpu_ack;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            m_sel = '0;
            if (exp_q.size() > 0 && cyc >= exp_q[0].acc && cyc <= exp_q[0].sel_end) m_sel = exp_q[0].sel;
            chk("slv_sel", slv_sel, m_sel);
            if (m_sel != 4'd0) begin
                chk("slv_write", slv_write, exp_q[0].wr);
                chk("slv_addr", slv_addr, exp_q[0].addr);
                chk("slv_wdata", slv_wdata, exp_q[0].wdata);
            end
            if (cpu_ack) begin
                if (exp_q.size() == 0) chk("unexpected_ack", cpu_ack, 0);
                else begin
                    m_e = exp_q.pop_front();
                    chk("ack_cycle", cyc, m_e.ack);
                    chk("bus_error", bus_error, m_e.err);
                    chk("cpu_rdata", cpu_rdata, m_e.rdata);
                    chk("err_addr", err_addr, m_e.eaddr);
                    chk("err_count", err_count, m_e.ecnt);
                end
            end else begin
                chk("bus_error_no_ack", bus_error, 0);
                if (exp_q.size() > 0 && cyc >= exp_q[0].ack) begin
                    m_e = exp_q.pop_front();
                    chk("ack_missing", cpu_ack, 1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0; slv_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_sel", slv_sel, 0);
        chk("reset_ack", cpu_ack, 0);
        chk("reset_error", bus_error, 0);
        chk("reset_rdata", cpu_rdata, 0);
        chk("reset_write", slv_write, 0);
        chk("reset_addr", slv_addr, 0);
        chk("reset_wdata", slv_wdata, 0);
        chk("reset_err_addr", err_addr, 0);
        chk("reset_err_count", err_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        rnd_rdata(); slv_rdata[15:0] = 16'hBEEF;
        txn(32'h0000_0010, 1'b0, 16'h0, 0, 1'b0);
        idle(1); rnd_rdata();
        txn(32'h0003_0004, 1'b1, 16'h1234, 0, 1'b0);
        idle(1); rnd_rdata();
        txn(32'h0002_0100, 1'b0, 16'h0, 6, 1'b0);
        idle(1); rnd_rdata();
        txn(32'h0002_0200, 1'b0, 16'h0, 1000, 1'b0);
        idle(1); rnd_rdata();
        txn(32'h0010_0000, 1'b0, 16'hFFFF, 0, 1'b0);
        idle(1); rnd_rdata();
        txn(32'h0002_0300, 1'b0, 16'h0, 7, 1'b0);

        for (int t = 0; t < 200; t++) begin
            bit chain = ($urandom_range(0, 3) == 0);
            int h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(0, 4));
            if (!chain) idle(int'($urandom_range(1, 3)));
            rnd_rdata();
            txn(rand_addr(), 1'($urandom), 16'($urandom), h, chain);
        end

        idle(2);
        mon_en = 1'b0;
        cpu_addr = 32'h0003_0000; cpu_write = 1'b0; cpu_req = 1'b1;
        @(negedge clk);
        chk("abort_sel_before", slv_sel, 4'b1000);
        @(negedge clk);
        cpu_req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        log_cnt = '0; log_addr = '0;
        chk("abort_sel", slv_sel, 0);
        chk("abort_ack", cpu_ack, 0);
        chk("abort_rdata", cpu_rdata, 0);
        chk("abort_err_count", err_count, log_cnt);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_ack", cpu_ack, 0);
            chk("abort_idle_sel", slv_sel, 0);
        end
        mon_en = 1'b1;
        rnd_rdata();
        txn(32'h0003_0008, 1'b0, 16'h0, 0, 1'b0);

        for (int t = 0; t < 300; t++) begin
            bit chain = ($urandom_range(0, 1) == 0);
            if (!chain) idle(1);
            txn({16'($urandom_range(4, 65535)), 16'($urandom)}, 1'($urandom), 16'($urandom), 0, chain);
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
